// File: rtl/pacman_pkg.sv
// Shared encodings, screen geometry and the per-axis step/clamp helper for Pacman motion.
package pacman_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned SPRITE_SIZE = 16;
  localparam int unsigned SCALE       = 4;
  localparam int unsigned MAX_X       = H_ACTIVE - SPRITE_SIZE * SCALE;
  localparam int unsigned MAX_Y       = V_ACTIVE - SPRITE_SIZE * SCALE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVING  = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       clamped;
  } step_t;

  // Landing exactly on 0 or max is legal; only overshoot counts as clamped.
  function automatic step_t step_axis(input logic [9:0] pos, input logic neg,
                                      input logic [9:0] step, input logic [9:0] max);
    logic signed [10:0] nxt;
    step_t              res;
    if (neg) nxt = $signed({1'b0, pos}) - $signed({1'b0, step});
    else     nxt = $signed({1'b0, pos}) + $signed({1'b0, step});
    res.clamped = 1'b0;
    res.pos     = nxt[9:0];
    if (nxt < 11'sd0) begin
      res.pos     = '0;
      res.clamped = 1'b1;
    end else if (nxt > $signed({1'b0, max})) begin
      res.pos     = max;
      res.clamped = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for a vector of asynchronous inputs.
module btn_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pacman_motion.sv
// Pacman position/facing/animation state, advanced once per video frame from the buttons.
module pacman_motion
  import pacman_pkg::*;
#(
  parameter int unsigned STEP        = 2,
  parameter int unsigned START_X     = 288,
  parameter int unsigned START_Y     = 208,
  parameter int unsigned MAX_X       = pacman_pkg::MAX_X,
  parameter int unsigned MAX_Y       = pacman_pkg::MAX_Y,
  parameter int unsigned ANIM_FRAMES = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  output logic [9:0] pac_x,
  output logic [9:0] pac_y,
  output logic [1:0] frame_select,
  output logic [1:0] facing,
  output logic       moving
);

  localparam int unsigned CW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  logic [3:0]    btn_s;
  logic          frame_tick_d;
  logic          tick_armed;
  logic          tick;
  logic          req_valid;
  logic [1:0]    req_dir;
  logic          go;
  logic [1:0]    dir;
  logic          horiz;
  logic          clamped;
  step_t         xs;
  step_t         ys;
  state_t        state;
  logic [CW-1:0] anim_cnt;

  btn_sync #(
    .WIDTH(4)
  ) u_btn_sync (
    .clk  (clk),
    .reset(reset),
    .d    ({btnU, btnD, btnL, btnR}),
    .q    (btn_s)
  );

  // tick_armed masks a strobe that was already high when reset released.
  assign tick = frame_tick & ~frame_tick_d & tick_armed;

  always_comb begin
    req_valid = |btn_s;
    if (btn_s[3])      req_dir = DIR_UP;
    else if (btn_s[2]) req_dir = DIR_DOWN;
    else if (btn_s[1]) req_dir = DIR_LEFT;
    else               req_dir = DIR_RIGHT;

    go  = 1'b0;
    dir = req_dir;
    unique case (state)
      IDLE:    go = req_valid;
      MOVING: begin
        go = 1'b1;
        if (!req_valid) dir = facing;
      end
      BLOCKED: go = req_valid && (req_dir != facing);
      default: go = 1'b0;
    endcase

    horiz   = (dir == DIR_LEFT) || (dir == DIR_RIGHT);
    xs      = step_axis(pac_x, dir == DIR_LEFT, 10'(STEP), 10'(MAX_X));
    ys      = step_axis(pac_y, dir == DIR_UP, 10'(STEP), 10'(MAX_Y));
    clamped = horiz ? xs.clamped : ys.clamped;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_tick_d <= 1'b0;
      tick_armed   <= 1'b0;
      state        <= IDLE;
      pac_x        <= 10'(START_X);
      pac_y        <= 10'(START_Y);
      facing       <= DIR_RIGHT;
      moving       <= 1'b0;
      frame_select <= '0;
      anim_cnt     <= '0;
    end else begin
      frame_tick_d <= frame_tick;
      tick_armed   <= 1'b1;
      if (tick && go) begin
        facing <= dir;
        if (horiz) pac_x <= xs.pos;
        else       pac_y <= ys.pos;
        state  <= clamped ? BLOCKED : MOVING;
        moving <= ~clamped;
        if (!clamped) begin
          if (anim_cnt == CW'(ANIM_FRAMES - 1)) begin
            anim_cnt     <= '0;
            frame_select <= frame_select + 2'd1;
          end else begin
            anim_cnt <= anim_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion: a vector table plus hand sequences for strobe/reset corners.
module tb_pacman_motion;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
  logic [9:0] pac_x, pac_y;
  logic [1:0] frame_select, facing;
  logic       moving;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pacman_motion dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .btnU        (btnU),
    .btnD        (btnD),
    .btnL        (btnL),
    .btnR        (btnR),
    .pac_x       (pac_x),
    .pac_y       (pac_y),
    .frame_select(frame_select),
    .facing      (facing),
    .moving      (moving)
  );

  // btn = {U, D, L, R}; rows are cumulative, do_reset restarts from reset values
  typedef struct {
    logic       do_reset;
    logic [3:0] btn;
    int         ticks;
    int         x;
    int         y;
    int         fac;
    int         mov;
    int         fs;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int x, input int y, input int fac,
                           input int mov, input int fs);
    check({tag, ".pac_x"}, int'(pac_x), x);
    check({tag, ".pac_y"}, int'(pac_y), y);
    check({tag, ".facing"}, int'(facing), fac);
    check({tag, ".moving"}, int'(moving), mov);
    check({tag, ".frame_select"}, int'(frame_select), fs);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btnU, btnD, btnL, btnR} = b;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'b0000,   5, 288, 208, 0, 0, 0};
    vecs[1]  = '{1'b0, 4'b0001,   2, 292, 208, 0, 1, 0};
    vecs[2]  = '{1'b0, 4'b0000,   3, 298, 208, 0, 1, 0};
    vecs[3]  = '{1'b0, 4'b1010,   1, 298, 206, 2, 1, 0};
    vecs[4]  = '{1'b0, 4'b0010, 149,   0, 206, 1, 1, 3};
    vecs[5]  = '{1'b0, 4'b0010,   1,   0, 206, 1, 0, 3};
    vecs[6]  = '{1'b0, 4'b0010,   3,   0, 206, 1, 0, 3};
    vecs[7]  = '{1'b0, 4'b0000,   2,   0, 206, 1, 0, 3};
    vecs[8]  = '{1'b0, 4'b0001,   1,   2, 206, 0, 1, 3};
    vecs[9]  = '{1'b1, 4'b0000,   0, 288, 208, 0, 0, 0};
    vecs[10] = '{1'b0, 4'b0001,  40, 368, 208, 0, 1, 2};
    vecs[11] = '{1'b0, 4'b0001, 104, 576, 208, 0, 1, 3};
    vecs[12] = '{1'b0, 4'b0001,   1, 576, 208, 0, 0, 3};
    vecs[13] = '{1'b0, 4'b0001,  30, 576, 208, 0, 0, 3};
    vecs[14] = '{1'b0, 4'b1000,   1, 576, 206, 2, 1, 3};
    vecs[15] = '{1'b0, 4'b0100,   1, 576, 208, 3, 1, 3};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all("reset", 288, 208, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].do_reset) do_reset();
      set_btn(vecs[i].btn);
      for (int t = 0; t < vecs[i].ticks; t++) do_tick();
      check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].fac, vecs[i].mov,
                vecs[i].fs);
    end

    // Strobe held four cycles yields a single step.
    do_reset();
    set_btn(4'b1000);
    @(negedge clk);
    frame_tick = 1'b1;
    repeat (4) @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check_all("held_tick", 288, 206, 2, 1, 0);

    // Asynchronous reset mid-frame, no clock edge in between.
    frame_tick = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_all("async_reset", 288, 208, 0, 0, 0);

    // Strobe already high at reset release must not tick.
    set_btn(4'b0001);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    check_all("no_tick_at_release", 288, 208, 0, 0, 0);
    do_tick();
    check_all("first_tick_after", 290, 208, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
